// File: rtl/sobel_uart_tx.sv
// sobel_uart_tx: buffers 16-bit RGB565 edge pixels in a small FIFO and
// sends each one back over UART, high byte first, as two 8N1 frames.
// Optional build macro SOBEL_UART_TX_PARITY_EN adds an even-parity bit,
// which makes each frame 8E1 (11 bits).
module sobel_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pi_flag,
    input  logic [15:0] pi_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_ovf
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SOBEL_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    // ---------------------------------------------------------------
    // Pixel FIFO
    // ---------------------------------------------------------------
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wr_en;
    logic             pop;
    logic [15:0]      rd_data;

    // A full FIFO refuses the word even if a pop frees a slot this cycle.
    assign wr_en   = pi_flag && (count_q != CNT_FULL);
    assign rd_data = mem[rd_ptr_q];

    // Pixel storage write port.
    // NOTE: the storage array has no reset; emptiness is tracked by count_q,
    // so clearing it would only cost flops and reset fan-out.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= pi_data;
        end
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (pi_flag && (count_q == CNT_FULL)) begin
            ovf_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // UART transmitter
    // ---------------------------------------------------------------
    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              byte_sel_q, byte_sel_d;
    logic [15:0]       word_q, word_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              baud_done;
    logic [2:0]        next_bit;
    logic [7:0]        cur_byte;

    assign baud_done = (baud_cnt_q == BAUD_LAST);
    assign next_bit  = bit_cnt_q + 3'd1;
    assign cur_byte  = byte_sel_q ? word_q[7:0] : word_q[15:8];

    // Frame sequencing, FIFO pop and registered tx/busy next-state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_done ? '0 : baud_cnt_q + BAUD_W'(1);
        bit_cnt_d  = bit_cnt_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    word_d     = rd_data;
                    byte_sel_d = 1'b0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    bit_cnt_d = '0;
                    tx_d      = cur_byte[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef SOBEL_UART_TX_PARITY_EN
                        tx_d    = ^cur_byte;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = next_bit;
                        tx_d      = cur_byte[next_bit];
                    end
                end
            end
`ifdef SOBEL_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (!byte_sel_q) begin
                        // Low byte follows the high byte with no idle gap.
                        byte_sel_d = 1'b1;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else if (count_q != '0) begin
                        // Next pixel goes straight out back-to-back.
                        pop        = 1'b1;
                        word_d     = rd_data;
                        byte_sel_d = 1'b0;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // State register for the FIFO control and the transmitter.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_sel_q <= 1'b0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign fifo_ovf = ovf_q;

endmodule

// File: tb/tb_sobel_uart_tx.sv
// Directed bench for sobel_uart_tx at BAUD_CNT_MAX = 10 (50 MHz / 5 Mbaud).
// Build with SOBEL_UART_TX_PARITY_EN defined to exercise the 8E1 frame.
module tb_sobel_uart_tx;

    localparam int BAUD  = 10;
    localparam int DEPTH = 16;
`ifdef SOBEL_UART_TX_PARITY_EN
    localparam int FRAME_CLK = 11 * BAUD;
`else
    localparam int FRAME_CLK = 10 * BAUD;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        pi_flag = 1'b0;
    logic [15:0] pi_data = 16'h0000;
    logic        tx;
    logic        busy;
    logic        fifo_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] drv_words [0:31];

    sobel_uart_tx #(
        .CLK_FREQ  (50_000_000),
        .UART_BPS  (5_000_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .pi_flag  (pi_flag),
        .pi_data  (pi_data),
        .tx       (tx),
        .busy     (busy),
        .fifo_ovf (fifo_ovf)
    );

    always #5 clk = ~clk;

    // Posedge count; read on negedges as a timestamp in clock cycles.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    // Receive one frame. Caller is on a negedge; the start bit is accepted at
    // the first negedge (including the current one) where tx is low, which is
    // cycle 0 of the bit. Returns on the stop-bit midpoint.
    task automatic recv_byte(output logic [7:0] b, output logic par,
                             output int t_start, output logic ok);
        int waited = 0;
        b = '0; par = 1'b0; t_start = 0; ok = 1'b1;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++;
            ok = 1'b0;
            $display("FAIL rx_start_timeout: tx=%b, required a start bit within 2000 cycles", tx);
            return;
        end
        t_start = cyc;
        repeat (BAUD / 2) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_start_mid: tx=%b at start-bit midpoint, required 0", tx);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = tx;
        end
`ifdef SOBEL_UART_TX_PARITY_EN
        repeat (BAUD) @(negedge clk);
        par = tx;
`endif
        repeat (BAUD) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_stop: tx=%b at stop-bit midpoint, required 1", tx);
        end
    endtask

    // Strobe drv_words[0..n-1] on consecutive edges from an idle DUT and
    // check every transmitted byte, latency, frame spacing, busy and overflow.
    task automatic run_pixels(input string name, input int n, input logic exp_ovf_end);
        int   n_tx;
        int   t_flag;
        int   t_end;
        int   guard;
        logic rx_ok;
        n_tx   = (n > DEPTH + 1) ? DEPTH + 1 : n;
        t_flag = cyc;
        rx_ok  = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    pi_flag = 1'b1;
                    pi_data = drv_words[i];
                    @(negedge clk);
                    // Only the strobe arriving with 16 words queued is dropped.
                    n_cmp++;
                    if (fifo_ovf !== ((i >= DEPTH + 1) ? 1'b1 : 1'b0)) begin
                        n_bad++;
                        $display("FAIL %s ovf_after_strobe%0d: fifo_ovf=%b, required %b",
                                 name, i, fifo_ovf, (i >= DEPTH + 1));
                    end
                end
                pi_flag = 1'b0;
            end
            begin
                logic [7:0]  b;
                logic [7:0]  exp_b;
                logic [15:0] w;
                logic        par;
                logic        ok;
                int          t;
                int          t_prev;
                t_prev = 0;
                @(negedge clk);
                for (int k = 0; k < 2 * n_tx; k++) begin
                    recv_byte(b, par, t, ok);
                    if (!ok) begin
                        rx_ok = 1'b0;
                        break;
                    end
                    w     = drv_words[k / 2];
                    exp_b = (k % 2 == 0) ? w[15:8] : w[7:0];
                    n_cmp++;
                    if (b !== exp_b) begin
                        n_bad++;
                        $display("FAIL %s byte%0d: got %02h, required %02h", name, k, b, exp_b);
                    end
`ifdef SOBEL_UART_TX_PARITY_EN
                    n_cmp++;
                    if (par !== ^exp_b) begin
                        n_bad++;
                        $display("FAIL %s parity%0d: got %b, required %b", name, k, par, ^exp_b);
                    end
`endif
                    n_cmp++;
                    if (k == 0) begin
                        if (t != t_flag + 2) begin
                            n_bad++;
                            $display("FAIL %s latency: start at cycle %0d, required %0d",
                                     name, t, t_flag + 2);
                        end
                    end else if (t - t_prev != FRAME_CLK) begin
                        n_bad++;
                        $display("FAIL %s spacing%0d: %0d cycles between starts, required %0d",
                                 name, k, t - t_prev, FRAME_CLK);
                    end
                    t_prev = t;
                end
            end
        join
        if (rx_ok) begin
            t_end = t_flag + 2 + 2 * n_tx * FRAME_CLK;
            guard = 0;
            while (cyc < t_end - 1 && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_before_end: busy=%b at cycle %0d, required 1", name, busy, cyc);
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                n_bad++;
                $display("FAIL %s idle_at_end: busy=%b tx=%b at cycle %0d, required busy=0 tx=1",
                         name, busy, tx, cyc);
            end
        end
        n_cmp++;
        if (fifo_ovf !== exp_ovf_end) begin
            n_bad++;
            $display("FAIL %s ovf_end: fifo_ovf=%b, required %b", name, fifo_ovf, exp_ovf_end);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: tx=%b busy=%b ovf=%b, required 1/0/0", tx, busy, fifo_ovf);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: tx=%b busy=%b ovf=%b, required 1/0/0", tx, busy, fifo_ovf);
        end
    endtask

    task automatic test_single();
        drv_words[0] = 16'hA55A;
        run_pixels("single", 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        drv_words[0] = 16'h0000;
        drv_words[1] = 16'hFFFF;
        drv_words[2] = 16'h1234;
        drv_words[3] = 16'h8001;
        run_pixels("b2b", 4, 1'b0);
    endtask

    // Second strobe lands on the same edge the idle FSM pops the first word.
    task automatic test_write_pop();
        drv_words[0] = 16'hC3A5;
        drv_words[1] = 16'h5AC3;
        run_pixels("write_pop", 2, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) begin
            drv_words[i] = {8'(i + 1), 8'(8'hF0 ^ 8'(i))};
        end
        run_pixels("overflow", 18, 1'b1);
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        int lows   = 0;
        pi_flag = 1'b1;
        pi_data = 16'hA55A;
        @(negedge clk);
        pi_flag = 1'b0;
        while (tx !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        // Cycle 0 of the start bit; bit 3 of 0xA5 (=0) spans cycles 40..49.
        repeat (45) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_before: tx=%b busy=%b in hi-byte bit 3, required 0/1", tx, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async: tx=%b busy=%b ovf=%b, required 1/0/0", tx, busy, fifo_ovf);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL midrst_quiet: %0d active samples after release, required 0", lows);
        end
        drv_words[0] = 16'h00FF;
        run_pixels("after_rst", 1, 1'b0);
    endtask

`ifdef SOBEL_UART_TX_PARITY_EN
    // 0x03 carries parity 0, 0x01 carries parity 1.
    task automatic test_parity();
        drv_words[0] = 16'h0301;
        run_pixels("parity", 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_write_pop();
        test_overflow();
        test_mid_reset();
`ifdef SOBEL_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
